// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares one external combinational ALU between NUM_REQ requesters using
// round-robin arbitration. One operation is in flight at a time. The winning
// requester's operands are registered onto the ALU inputs. The ALU result is
// captured one cycle later and returned on a valid/ready response channel,
// tagged with the requester index.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   req_valid   per-requester request valid            [NUM_REQ]
//   req_ready   per-requester accept, one-hot or zero  [NUM_REQ]
//   req_a       packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b       packed operand B, same packing
//   req_op      packed opcode, requester i at [i*3 +: 3]
//   alu_a       registered operand A to the ALU
//   alu_b       registered operand B to the ALU
//   alu_op      registered opcode to the ALU
//   alu_result  combinational result from the ALU
//   rsp_valid   response valid
//   rsp_ready   response consumer ready
//   rsp_id      requester index of the response
//   rsp_result  captured ALU result
//   rsp_err     opcode was unsupported (3'b101..3'b111)
// -----------------------------------------------------------------------------
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] grant_sel;
    logic           grant_found;

    // Round-robin search: walk the requesters starting at rr_ptr and take the
    // first one with valid set, wrapping modulo NUM_REQ (which need not be a
    // power of two, so the wrap is done explicitly).
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_sel   = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDW'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_sel   = cand;
            end
        end
    end

    // Accept is combinational and only ever offered while idle and out of
    // reset, so requesters see it in the same cycle the grant is decided.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready[grant_sel] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath. rr_ptr moves only on a completed response handshake, so a
    // requester that keeps its valid high cannot be granted twice in a row
    // while others are waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        grant_id <= grant_sel;
                        alu_a    <= req_a[int'(grant_sel)*WIDTH +: WIDTH];
                        alu_b    <= req_b[int'(grant_sel)*WIDTH +: WIDTH];
                        alu_op   <= req_op[int'(grant_sel)*3 +: 3];
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_id     <= grant_id;
                    rsp_err    <= (alu_op > 3'b100);
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (grant_id == IDW'(NUM_REQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant_id + 1'b1;
                        end
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_arbiter
//
// Testbench for alu_rr_arbiter. It supplies a small behavioural ALU, drives
// directed and randomized requests, and checks the grant order, the operand
// routing, the response contents and the handshake timing against a
// round-robin reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_alu_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int IDW     = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*3-1:0]     req_op;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [2:0]               alu_op;
    logic [WIDTH-1:0]         alu_result;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_err;

    int vectors     = 0;
    int miscompares = 0;
    int rr_model    = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WIDTH  (WIDTH),
        .IDW    (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_result(rsp_result),
        .rsp_err   (rsp_err)
    );

    // Behavioural ALU: add, sub, and, or, xor; anything else yields zero.
    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0] op);
        int r;
        case (op)
            3'd0:    r = (int'(a) + int'(b)) % 16;
            3'd1:    r = (int'(a) - int'(b) + 16) % 16;
            3'd2:    r = int'(a & b);
            3'd3:    r = int'(a | b);
            3'd4:    r = int'(a ^ b);
            default: r = 0;
        endcase
        return WIDTH'(r);
    endfunction

    assign alu_result = ref_alu(alu_a, alu_b, alu_op);

    // Round-robin reference: first valid requester at or after the pointer.
    function automatic int pick_grant(input logic [NUM_REQ-1:0] mask, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mask[(ptr + k) % NUM_REQ]) begin
                return (ptr + k) % NUM_REQ;
            end
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] op);
        req_valid[idx]           = valid;
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        req_op[idx*3 +: 3]        = op;
    endtask

    // One full transaction in lock-step, entered just after an edge with the
    // arbiter idle. hold = number of RESP cycles with rsp_ready low.
    task automatic run_txn(input string tag, input int g, input logic [WIDTH-1:0] exp_res,
                           input logic exp_err, input int hold);
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        logic [2:0]       eop;
        @(negedge clk);
        checkOutput({tag, " grant"}, 32'(req_ready), 32'(1 << g));
        checkOutput({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
        ea  = req_a[g*WIDTH +: WIDTH];
        eb  = req_b[g*WIDTH +: WIDTH];
        eop = req_op[g*3 +: 3];
        @(posedge clk);
        #1;
        rsp_ready = (hold == 0);
        @(negedge clk);
        checkOutput({tag, " exec req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, " alu_a"}, 32'(alu_a), 32'(ea));
        checkOutput({tag, " alu_b"}, 32'(alu_b), 32'(eb));
        checkOutput({tag, " alu_op"}, 32'(alu_op), 32'(eop));
        @(posedge clk);
        #1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, " hold rsp_result"}, 32'(rsp_result), 32'(exp_res));
            checkOutput({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            if (i == hold - 1) begin
                rsp_ready = 1'b1;
            end
        end
        @(negedge clk);
        checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, " rsp_id"}, 32'(rsp_id), 32'(g));
        checkOutput({tag, " rsp_result"}, 32'(rsp_result), 32'(exp_res));
        checkOutput({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        checkOutput({tag, " resp alu_a held"}, 32'(alu_a), 32'(ea));
        checkOutput({tag, " resp req_ready"}, 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rr_model = (g + 1) % NUM_REQ;
    endtask

    // Global time bound so a stuck run still reports and ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        int slot;
        logic [WIDTH-1:0] ga;
        logic [WIDTH-1:0] gb;
        logic [2:0]       gop;

        $display("[TB] start");
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        applyStimulus(0, 1'b1, 4'd9, 4'd8, 3'b000);
        applyStimulus(1, 1'b1, 4'd3, 4'd5, 3'b001);
        applyStimulus(2, 1'b1, 4'hA, 4'h5, 3'b100);
        applyStimulus(3, 1'b1, 4'h7, 4'h1, 3'b110);

        // Reset held two cycles with every requester asking.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("reset req_ready", 32'(req_ready), 32'd0);
            checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("reset alu_a", 32'(alu_a), 32'd0);
            checkOutput("reset alu_b", 32'(alu_b), 32'd0);
            checkOutput("reset alu_op", 32'(alu_op), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rr_model = 0;

        // Add with wrap, then fairness order 1,2,3,0 with all valid.
        run_txn("add req0", 0, 4'h1, 1'b0, 0);
        run_txn("sub req1", 1, 4'hE, 1'b0, 0);
        run_txn("xor req2 backpressure", 2, 4'hF, 1'b0, 5);
        run_txn("badop req3", 3, 4'h0, 1'b1, 0);
        run_txn("wrap req0", 0, 4'h1, 1'b0, 0);

        // Reset during RESP of req1; pointer must return to requester 0.
        applyStimulus(0, 1'b1, 4'h6, 4'h3, 3'b010);
        applyStimulus(2, 1'b0, 4'h0, 4'h0, 3'b000);
        applyStimulus(3, 1'b0, 4'h0, 4'h0, 3'b000);
        @(negedge clk);
        checkOutput("midrst grant", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midrst rsp_valid before", 32'(rsp_valid), 32'd1);
        checkOutput("midrst rsp_id before", 32'(rsp_id), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("midrst alu_op", 32'(alu_op), 32'd0);
        checkOutput("midrst req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rr_model = 0;
        run_txn("after reset req0", 0, 4'h2, 1'b0, 0);

        // Randomized traffic against the round-robin model.
        for (int i = 0; i < NUM_REQ; i++) begin
            applyStimulus(i, 1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
        end
        if (req_valid == '0) begin
            req_valid[0] = 1'b1;
        end
        for (int t = 0; t < 40; t++) begin
            g   = pick_grant(req_valid, rr_model);
            ga  = req_a[g*WIDTH +: WIDTH];
            gb  = req_b[g*WIDTH +: WIDTH];
            gop = req_op[g*3 +: 3];
            run_txn("random", g, ref_alu(ga, gb, gop), (gop > 3'b100),
                    int'($urandom_range(0, 3)));
            applyStimulus(g, 1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
            if (req_valid == '0) begin
                slot = int'($urandom_range(0, NUM_REQ - 1));
                applyStimulus(slot, 1'b1, 4'($urandom), 4'($urandom), 3'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
